// File: rtl/keypad_matrix_scanner.sv
// 4x4 active-low keypad scanner: row drive, column synchroniser, frame debounce,
// and sticky press flags with a one-cycle interrupt for the keyboard peripheral.
module keypad_matrix_scanner #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 5
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [3:0]  col_in,
    output logic [3:0]  row_out,
    output logic [15:0] key_data,
    input  logic        key_clear,
    output logic        key_irq
);

    localparam int DIV_W  = $clog2(SCAN_DIV);
    localparam int DCNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DEBOUNCE_CNT);

    function automatic logic [DCNT_W-1:0] sat_inc(input logic [DCNT_W-1:0] v);
        if (v >= DCNT_MAX) return DCNT_MAX;
        return v + DCNT_W'(1);
    endfunction

    logic [3:0]        col_meta_p0;
    logic [3:0]        col_s;
    logic [DIV_W-1:0]  div_cnt;
    logic [1:0]        row_idx;
    logic [1:0]        row_nxt;
    logic [15:0]       raw;
    logic [15:0]       prev_raw;
    logic [15:0]       stable;
    logic [DCNT_W-1:0] dcnt;

    logic              sample;
    logic              frame_end;
    logic [15:0]       raw_nxt;
    logic [15:0]       stable_nxt;
    logic [15:0]       rise;
    logic [DCNT_W-1:0] dcnt_nxt;

    assign sample    = (div_cnt == DIV_LAST);
    assign frame_end = sample && (row_idx == 2'd3);
    assign row_nxt   = row_idx + 2'd1;

    // Stage boundary: two-flop column synchroniser
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            col_meta_p0 <= '0;
            col_s       <= '0;
        end else begin
            col_meta_p0 <= col_in;
            col_s       <= col_meta_p0;
        end
    end

    // Stage boundary: row scan; row_out switches together with the index on wrap
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            div_cnt <= '0;
            row_idx <= '0;
            row_out <= 4'b1110;
        end else if (sample) begin
            div_cnt <= '0;
            row_idx <= row_nxt;
            row_out <= ~(4'b0001 << row_nxt);
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // The row-3 sample is folded into raw_nxt so the frame decision sees the full matrix
    always_comb begin
        raw_nxt    = raw;
        dcnt_nxt   = dcnt;
        stable_nxt = stable;
        rise       = '0;
        if (sample) begin
            raw_nxt[{row_idx, 2'b00} +: 4] = ~col_s;
        end
        if (frame_end) begin
            dcnt_nxt = (raw_nxt != prev_raw) ? DCNT_W'(1) : sat_inc(dcnt);
            if (dcnt_nxt == DCNT_MAX) begin
                stable_nxt = raw_nxt;
            end
            rise = stable_nxt & ~stable;
        end
    end

    // Stage boundary: debounce state
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            raw      <= '0;
            prev_raw <= '0;
            dcnt     <= '0;
            stable   <= '0;
        end else begin
            raw    <= raw_nxt;
            dcnt   <= dcnt_nxt;
            stable <= stable_nxt;
            if (frame_end) begin
                prev_raw <= raw_nxt;
            end
        end
    end

    // Stage boundary: sticky flags; a new press wins over a coincident clear
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            key_data <= '0;
            key_irq  <= 1'b0;
        end else begin
            key_data <= (key_clear ? 16'h0000 : key_data) | rise;
            key_irq  <= |rise;
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner with a behavioural keypad and an
// interrupt scoreboard holding the expected flag value and cycle of each key_irq.
module tb_keypad_matrix_scanner;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [15:0] key_data;
    logic        key_clear = 1'b0;
    logic        key_irq;

    logic [15:0] keys = 16'h0000;
    int          vectors = 0;
    int          errors = 0;
    int          cyc;

    typedef struct {
        logic [15:0] data;
        int          cyc_at;
    } exp_t;

    exp_t sb[$];

    keypad_matrix_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_data  (key_data),
        .key_clear (key_clear),
        .key_irq   (key_irq)
    );

    always #5 HCLK = ~HCLK;

    // A column reads low when any pressed key on it sits in a driven row
    always_comb begin
        col_in = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!row_out[r] && keys[r*4 + c]) col_in[c] = 1'b0;
            end
        end
    end

    // Bench-side cycle count since reset release
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic goto(input int n);
        while (cyc < n) tick();
    endtask

    task automatic expect_flag(input logic [15:0] d, input int at);
        sb.push_back('{data: d, cyc_at: at});
    endtask

    always @(negedge HCLK) begin
        exp_t e;
        if (HRESETn && key_irq) begin
            if (sb.size() == 0) begin
                check("irq_unexpected", 16'(cyc), 16'hFFFF);
            end else begin
                e = sb.pop_front();
                check("irq_cycle", 16'(cyc), 16'(e.cyc_at));
                check("irq_data", key_data, e.data);
            end
        end
    end

    initial begin
        logic [3:0] exp_row;

        // Reset values
        repeat (3) @(posedge HCLK);
        #1;
        check("rst_row_out", {12'h000, row_out}, 16'h000E);
        check("rst_key_data", key_data, 16'h0000);
        check("rst_key_irq", {15'h0, key_irq}, 16'h0000);
        HRESETn = 1'b1;

        // Free-running row scan, four cycles per row
        for (int k = 0; k <= 16; k++) begin
            goto(k);
            exp_row = 4'b0001 << ((k / 4) % 4);
            check("row_out", {12'h000, row_out}, {12'h000, ~exp_row});
        end

        // Steady press of row1/col2
        goto(32);
        keys = 16'h0040;
        expect_flag(16'h0040, 80);
        goto(79);
        check("press_early", key_data, 16'h0000);
        goto(80);
        check("press_flag", key_data, 16'h0040);
        goto(81);
        check("press_irq_pulse", {15'h0, key_irq}, 16'h0000);
        goto(128);
        check("press_held", key_data, 16'h0040);
        keys = 16'h0000;
        goto(176);
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        check("clear_after_release", key_data, 16'h0000);

        // Bounce: toggle every 8 cycles for 64 cycles, then hold
        goto(184);
        for (int i = 0; i < 8; i++) begin
            keys = (i % 2 == 0) ? 16'h0040 : 16'h0000;
            repeat (8) tick();
        end
        keys = 16'h0040;
        expect_flag(16'h0040, 304);
        goto(303);
        check("bounce_no_flag", key_data, 16'h0000);
        goto(304);
        check("bounce_then_flag", key_data, 16'h0040);

        // Hold key0, clear, no re-flag until released and pressed again
        keys = 16'h0001;
        expect_flag(16'h0041, 352);
        goto(352);
        check("key0_flag", key_data, 16'h0041);
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        check("key0_cleared", key_data, 16'h0000);
        goto(400);
        check("key0_no_reflag", key_data, 16'h0000);
        keys = 16'h0000;
        goto(448);
        keys = 16'h0001;
        expect_flag(16'h0001, 496);
        goto(495);
        check("key0_repress_early", key_data, 16'h0000);
        goto(496);
        check("key0_reflag", key_data, 16'h0001);

        // Clear coinciding with the rise of key15
        keys = 16'h8000;
        expect_flag(16'h8000, 544);
        goto(543);
        check("key15_before", key_data, 16'h0001);
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        check("set_wins_data", key_data, 16'h8000);
        check("set_wins_irq", {15'h0, key_irq}, 16'h0001);

        // Two keys held through an asynchronous mid-frame reset
        keys = 16'h1008;
        goto(552);
        check("pre_reset_data", key_data, 16'h8000);
        HRESETn = 1'b0;
        #1;
        check("async_rst_row_out", {12'h000, row_out}, 16'h000E);
        check("async_rst_key_data", key_data, 16'h0000);
        check("async_rst_key_irq", {15'h0, key_irq}, 16'h0000);
        repeat (2) tick();
        HRESETn = 1'b1;
        expect_flag(16'h1008, 48);
        goto(4);
        check("post_rst_row_out", {12'h000, row_out}, 16'h000D);
        goto(47);
        check("post_rst_early", key_data, 16'h0000);
        goto(48);
        check("post_rst_flag", key_data, 16'h1008);
        goto(80);
        check("sb_drained", 16'(sb.size()), 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
